sram_like_arbiter: RTL and testbench

- N-channel sram-like request arbiter that merges several core-side masters (inst fetch, data load/store, future TLB-refill/cache-refill ports) onto one downstream sram-like slave, e.g. the AXI bridge.
- Tracks in-order outstanding transactions in an ID FIFO and routes each downstream data_ok/rdata back to the issuing channel.
- Generalises the fixed two-channel inst/data split to NUM_CH channels, with selectable arbitration mode and bounded outstanding depth.

---
 rtl/sram_like_arbiter.sv | 148 ++++++++++++++
 tb/tb_sram_like_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// N-channel sram-like request arbiter merging several masters onto one sram-like slave.
// In-order ID FIFO routes each downstream data_ok/rdata back to the issuing channel.
module sram_like_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int MAX_OUTST = 4,
  parameter int ARB_MODE  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            m_req,
  input  logic [NUM_CH-1:0]            m_wr,
  input  logic [2*NUM_CH-1:0]          m_size,
  input  logic [4*NUM_CH-1:0]          m_wstrb,
  input  logic [32*NUM_CH-1:0]         m_addr,
  input  logic [32*NUM_CH-1:0]         m_wdata,
  output logic [NUM_CH-1:0]            m_addr_ok,
  output logic [NUM_CH-1:0]            m_data_ok,
  output logic [31:0]                  m_rdata,
  output logic                         s_req,
  output logic                         s_wr,
  output logic [1:0]                   s_size,
  output logic [3:0]                   s_wstrb,
  output logic [31:0]                  s_addr,
  output logic [31:0]                  s_wdata,
  input  logic                         s_addr_ok,
  input  logic                         s_data_ok,
  input  logic [31:0]                  s_rdata,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         err_spurious
);

  localparam int PW  = $clog2(MAX_OUTST);
  localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PW:0] MAX_CNT = (PW+1)'(MAX_OUTST);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]    cnt_q, cnt_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d;
  logic           err_q, err_d;
  logic [IDW-1:0] fifo_q [MAX_OUTST];
  logic [IDW-1:0] fifo_d [MAX_OUTST];

  logic [IDW-1:0] winner, grant, head_id;
  logic           full, push, pop, found;
  int             idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (ARB_MODE == 1) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!found && m_req[idx]) begin
          winner = IDW'(idx);
          found  = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (m_req[i]) winner = IDW'(i);
      end
    end
  end

  // A locked channel keeps the grant until the slave accepts its address.
  always_comb begin
    full  = (cnt_q == MAX_CNT);
    grant = (state_q == LOCKED) ? lock_id_q : winner;
    if (reset)                 s_req = 1'b0;
    else if (state_q == LOCKED) s_req = m_req[lock_id_q];
    else                       s_req = (|m_req) & ~full;

    s_wr    = m_wr[grant];
    s_size  = m_size[int'(grant)*2 +: 2];
    s_wstrb = m_wstrb[int'(grant)*4 +: 4];
    s_addr  = m_addr[int'(grant)*32 +: 32];
    s_wdata = m_wdata[int'(grant)*32 +: 32];

    push = s_req & s_addr_ok;
    m_addr_ok = '0;
    if (push) m_addr_ok[grant] = 1'b1;

    head_id = fifo_q[rd_ptr_q];
    pop = ~reset & s_data_ok & (cnt_q != '0);
    m_data_ok = '0;
    if (pop) m_data_ok[head_id] = 1'b1;
    m_rdata = s_rdata;
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    fifo_d    = fifo_q;
    cnt_d     = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    err_d     = err_q | (s_data_ok & (cnt_q == '0));

    if (state_q == IDLE) begin
      if (s_req && !s_addr_ok) begin
        state_d   = LOCKED;
        lock_id_d = grant;
      end
    end else if (s_addr_ok) begin
      state_d = IDLE;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = grant;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (ARB_MODE == 1)
        rr_ptr_d = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
      fifo_q    <= fifo_d;
    end
  end

  assign outst_cnt    = cnt_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: fixed-priority 2-channel instance and round-robin 3-channel instance.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Instance A: NUM_CH=2, fixed priority
  logic [1:0]  a_req, a_wr, a_size_unused;
  logic [3:0]  a_size;
  logic [7:0]  a_wstrb;
  logic [63:0] a_addr, a_wdata;
  logic [1:0]  a_m_addr_ok, a_m_data_ok;
  logic [31:0] a_m_rdata, a_s_addr, a_s_wdata, a_s_rdata;
  logic        a_s_req, a_s_wr, a_s_addr_ok, a_s_data_ok, a_err;
  logic [1:0]  a_s_size;
  logic [3:0]  a_s_wstrb;
  logic [2:0]  a_outst;

  // Instance B: NUM_CH=3, round-robin
  logic [2:0]  b_req, b_wr;
  logic [5:0]  b_size;
  logic [11:0] b_wstrb;
  logic [95:0] b_addr, b_wdata;
  logic [2:0]  b_m_addr_ok, b_m_data_ok;
  logic [31:0] b_m_rdata, b_s_addr, b_s_wdata, b_s_rdata;
  logic        b_s_req, b_s_wr, b_s_addr_ok, b_s_data_ok, b_err;
  logic [1:0]  b_s_size;
  logic [3:0]  b_s_wstrb;
  logic [2:0]  b_outst;

  sram_like_arbiter #(.NUM_CH(2), .MAX_OUTST(4), .ARB_MODE(0)) dut_a (
    .clk(clk), .reset(reset),
    .m_req(a_req), .m_wr(a_wr), .m_size(a_size), .m_wstrb(a_wstrb),
    .m_addr(a_addr), .m_wdata(a_wdata),
    .m_addr_ok(a_m_addr_ok), .m_data_ok(a_m_data_ok), .m_rdata(a_m_rdata),
    .s_req(a_s_req), .s_wr(a_s_wr), .s_size(a_s_size), .s_wstrb(a_s_wstrb),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata),
    .s_addr_ok(a_s_addr_ok), .s_data_ok(a_s_data_ok), .s_rdata(a_s_rdata),
    .outst_cnt(a_outst), .err_spurious(a_err)
  );

  sram_like_arbiter #(.NUM_CH(3), .MAX_OUTST(4), .ARB_MODE(1)) dut_b (
    .clk(clk), .reset(reset),
    .m_req(b_req), .m_wr(b_wr), .m_size(b_size), .m_wstrb(b_wstrb),
    .m_addr(b_addr), .m_wdata(b_wdata),
    .m_addr_ok(b_m_addr_ok), .m_data_ok(b_m_data_ok), .m_rdata(b_m_rdata),
    .s_req(b_s_req), .s_wr(b_s_wr), .s_size(b_s_size), .s_wstrb(b_s_wstrb),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata),
    .s_addr_ok(b_s_addr_ok), .s_data_ok(b_s_data_ok), .s_rdata(b_s_rdata),
    .outst_cnt(b_outst), .err_spurious(b_err)
  );

  localparam logic [31:0] A_ADDR0 = 32'h0000_0200;
  localparam logic [31:0] A_ADDR1 = 32'h1000_0100;

  task automatic test_reset;
    reset = 1'b1;
    a_req = 2'b11; a_s_addr_ok = 1'b1; a_s_data_ok = 1'b1;
    #2;
    vec_cnt++; if (a_s_req !== 1'b0) begin err_cnt++; $display("[TB] FAIL rst_s_req: got %b want 0", a_s_req); end
    vec_cnt++; if (a_m_addr_ok !== 2'b00) begin err_cnt++; $display("[TB] FAIL rst_addr_ok: got %b want 00", a_m_addr_ok); end
    vec_cnt++; if (a_m_data_ok !== 2'b00) begin err_cnt++; $display("[TB] FAIL rst_data_ok: got %b want 00", a_m_data_ok); end
    vec_cnt++; if (a_outst !== 3'd0) begin err_cnt++; $display("[TB] FAIL rst_outst: got %0d want 0", a_outst); end
    vec_cnt++; if (a_err !== 1'b0) begin err_cnt++; $display("[TB] FAIL rst_err: got %b want 0", a_err); end
    vec_cnt++; if (b_outst !== 3'd0) begin err_cnt++; $display("[TB] FAIL rst_b_outst: got %0d want 0", b_outst); end
    @(negedge clk);
    reset = 1'b0;
    a_req = 2'b00; a_s_addr_ok = 1'b0; a_s_data_ok = 1'b0;
  endtask

  task automatic test_fixed_priority;
    @(negedge clk);
    a_req = 2'b11; a_s_addr_ok = 1'b1;
    #1;
    vec_cnt++; if (a_s_req !== 1'b1) begin err_cnt++; $display("[TB] FAIL fp_s_req: got %b want 1", a_s_req); end
    vec_cnt++; if (a_m_addr_ok !== 2'b01) begin err_cnt++; $display("[TB] FAIL fp_addr_ok: got %b want 01", a_m_addr_ok); end
    vec_cnt++; if (a_s_addr !== A_ADDR0) begin err_cnt++; $display("[TB] FAIL fp_s_addr: got %h want %h", a_s_addr, A_ADDR0); end
    vec_cnt++; if (a_s_wdata !== 32'hD0D0_0000) begin err_cnt++; $display("[TB] FAIL fp_s_wdata: got %h want d0d00000", a_s_wdata); end
    vec_cnt++; if (a_s_wstrb !== 4'h3) begin err_cnt++; $display("[TB] FAIL fp_s_wstrb: got %h want 3", a_s_wstrb); end
    vec_cnt++; if (a_s_size !== 2'b10) begin err_cnt++; $display("[TB] FAIL fp_s_size: got %b want 10", a_s_size); end
    vec_cnt++; if (a_s_wr !== 1'b1) begin err_cnt++; $display("[TB] FAIL fp_s_wr: got %b want 1", a_s_wr); end
    @(posedge clk); #1;
    vec_cnt++; if (a_outst !== 3'd1) begin err_cnt++; $display("[TB] FAIL fp_outst: got %0d want 1", a_outst); end
    @(negedge clk);
    a_req = 2'b00; a_s_addr_ok = 1'b0; a_s_data_ok = 1'b1; a_s_rdata = 32'h1234_5678;
    #1;
    vec_cnt++; if (a_m_data_ok !== 2'b01) begin err_cnt++; $display("[TB] FAIL fp_data_ok: got %b want 01", a_m_data_ok); end
    vec_cnt++; if (a_m_rdata !== 32'h1234_5678) begin err_cnt++; $display("[TB] FAIL fp_rdata: got %h want 12345678", a_m_rdata); end
    @(posedge clk); #1;
    vec_cnt++; if (a_outst !== 3'd0) begin err_cnt++; $display("[TB] FAIL fp_drain: got %0d want 0", a_outst); end
    @(negedge clk);
    a_s_data_ok = 1'b0;
  endtask

  task automatic test_lock_hold;
    a_req = 2'b10; a_s_addr_ok = 1'b0;
    #1;
    vec_cnt++; if (a_s_req !== 1'b1) begin err_cnt++; $display("[TB] FAIL lk_c1_s_req: got %b want 1", a_s_req); end
    vec_cnt++; if (a_s_addr !== A_ADDR1) begin err_cnt++; $display("[TB] FAIL lk_c1_addr: got %h want %h", a_s_addr, A_ADDR1); end
    vec_cnt++; if (a_m_addr_ok !== 2'b00) begin err_cnt++; $display("[TB] FAIL lk_c1_addr_ok: got %b want 00", a_m_addr_ok); end
    @(posedge clk);
    @(negedge clk);
    a_req = 2'b11;
    #1;
    vec_cnt++; if (a_s_addr !== A_ADDR1) begin err_cnt++; $display("[TB] FAIL lk_c2_addr: got %h want %h", a_s_addr, A_ADDR1); end
    vec_cnt++; if (a_s_size !== 2'b01) begin err_cnt++; $display("[TB] FAIL lk_c2_size: got %b want 01", a_s_size); end
    vec_cnt++; if (a_m_addr_ok !== 2'b00) begin err_cnt++; $display("[TB] FAIL lk_c2_addr_ok: got %b want 00", a_m_addr_ok); end
    @(posedge clk);
    @(negedge clk);
    #1;
    vec_cnt++; if (a_s_addr !== A_ADDR1) begin err_cnt++; $display("[TB] FAIL lk_c3_addr: got %h want %h", a_s_addr, A_ADDR1); end
    @(posedge clk);
    @(negedge clk);
    a_s_addr_ok = 1'b1;
    #1;
    vec_cnt++; if (a_m_addr_ok !== 2'b10) begin err_cnt++; $display("[TB] FAIL lk_c4_addr_ok: got %b want 10", a_m_addr_ok); end
    vec_cnt++; if (a_s_addr !== A_ADDR1) begin err_cnt++; $display("[TB] FAIL lk_c4_addr: got %h want %h", a_s_addr, A_ADDR1); end
    @(posedge clk); #1;
    vec_cnt++; if (a_outst !== 3'd1) begin err_cnt++; $display("[TB] FAIL lk_outst: got %0d want 1", a_outst); end
    // Back in IDLE, so channel 0 now wins over channel 1
    @(negedge clk);
    #1;
    vec_cnt++; if (a_m_addr_ok !== 2'b01) begin err_cnt++; $display("[TB] FAIL lk_idle_addr_ok: got %b want 01", a_m_addr_ok); end
    @(posedge clk); #1;
    vec_cnt++; if (a_outst !== 3'd2) begin err_cnt++; $display("[TB] FAIL lk_outst2: got %0d want 2", a_outst); end
  endtask

  task automatic test_in_order_return;
    @(negedge clk);
    a_req = 2'b00; a_s_addr_ok = 1'b0; a_s_data_ok = 1'b1; a_s_rdata = 32'hAAAA_0001;
    #1;
    vec_cnt++; if (a_m_data_ok !== 2'b10) begin err_cnt++; $display("[TB] FAIL ret1_data_ok: got %b want 10", a_m_data_ok); end
    vec_cnt++; if (a_m_rdata !== 32'hAAAA_0001) begin err_cnt++; $display("[TB] FAIL ret1_rdata: got %h want aaaa0001", a_m_rdata); end
    @(posedge clk); #1;
    vec_cnt++; if (a_outst !== 3'd1) begin err_cnt++; $display("[TB] FAIL ret1_outst: got %0d want 1", a_outst); end
    @(negedge clk);
    a_s_rdata = 32'hBBBB_0002;
    #1;
    vec_cnt++; if (a_m_data_ok !== 2'b01) begin err_cnt++; $display("[TB] FAIL ret2_data_ok: got %b want 01", a_m_data_ok); end
    vec_cnt++; if (a_m_rdata !== 32'hBBBB_0002) begin err_cnt++; $display("[TB] FAIL ret2_rdata: got %h want bbbb0002", a_m_rdata); end
    @(posedge clk); #1;
    vec_cnt++; if (a_outst !== 3'd0) begin err_cnt++; $display("[TB] FAIL ret2_outst: got %0d want 0", a_outst); end
    @(negedge clk);
    a_s_data_ok = 1'b0;
  endtask

  task automatic test_full_boundary;
    logic [2:0] exp_cnt;
    a_req = 2'b01; a_s_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp_cnt = 3'(i + 1);
      vec_cnt++; if (a_outst !== exp_cnt) begin err_cnt++; $display("[TB] FAIL full_fill%0d: got %0d want %0d", i, a_outst, exp_cnt); end
      @(negedge clk);
    end
    #1;
    vec_cnt++; if (a_s_req !== 1'b0) begin err_cnt++; $display("[TB] FAIL full_s_req: got %b want 0", a_s_req); end
    vec_cnt++; if (a_m_addr_ok !== 2'b00) begin err_cnt++; $display("[TB] FAIL full_addr_ok: got %b want 00", a_m_addr_ok); end
    @(posedge clk); #1;
    vec_cnt++; if (a_outst !== 3'd4) begin err_cnt++; $display("[TB] FAIL full_hold: got %0d want 4", a_outst); end
    // A same-cycle pop does not unblock issue
    @(negedge clk);
    a_s_data_ok = 1'b1; a_s_rdata = 32'h0000_00F1;
    #1;
    vec_cnt++; if (a_s_req !== 1'b0) begin err_cnt++; $display("[TB] FAIL full_pop_s_req: got %b want 0", a_s_req); end
    vec_cnt++; if (a_m_data_ok !== 2'b01) begin err_cnt++; $display("[TB] FAIL full_pop_data_ok: got %b want 01", a_m_data_ok); end
    @(posedge clk); #1;
    vec_cnt++; if (a_outst !== 3'd3) begin err_cnt++; $display("[TB] FAIL full_pop_outst: got %0d want 3", a_outst); end
    @(negedge clk);
    #1;
    vec_cnt++; if (a_s_req !== 1'b1) begin err_cnt++; $display("[TB] FAIL full_resume_s_req: got %b want 1", a_s_req); end
    vec_cnt++; if (a_m_addr_ok !== 2'b01) begin err_cnt++; $display("[TB] FAIL full_resume_addr_ok: got %b want 01", a_m_addr_ok); end
    vec_cnt++; if (a_m_data_ok !== 2'b01) begin err_cnt++; $display("[TB] FAIL full_both_data_ok: got %b want 01", a_m_data_ok); end
    @(posedge clk); #1;
    vec_cnt++; if (a_outst !== 3'd3) begin err_cnt++; $display("[TB] FAIL full_pushpop_outst: got %0d want 3", a_outst); end
    @(negedge clk);
    a_req = 2'b00; a_s_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      exp_cnt = 3'(2 - i);
      vec_cnt++; if (a_outst !== exp_cnt) begin err_cnt++; $display("[TB] FAIL full_drain%0d: got %0d want %0d", i, a_outst, exp_cnt); end
    end
    @(negedge clk);
    a_s_data_ok = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [2:0]  exp_onehot [4];
    logic [31:0] exp_addr [4];
    exp_onehot = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_addr   = '{32'hB000_0000, 32'hB000_0010, 32'hB000_0020, 32'hB000_0000};
    @(negedge clk);
    b_req = 3'b111; b_s_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vec_cnt++; if (b_m_addr_ok !== exp_onehot[i]) begin err_cnt++; $display("[TB] FAIL rr_grant%0d: got %b want %b", i, b_m_addr_ok, exp_onehot[i]); end
      vec_cnt++; if (b_s_addr !== exp_addr[i]) begin err_cnt++; $display("[TB] FAIL rr_addr%0d: got %h want %h", i, b_s_addr, exp_addr[i]); end
      @(negedge clk);
    end
    vec_cnt++; if (b_outst !== 3'd4) begin err_cnt++; $display("[TB] FAIL rr_outst: got %0d want 4", b_outst); end
    b_req = 3'b000; b_s_addr_ok = 1'b0; b_s_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vec_cnt++; if (b_m_data_ok !== exp_onehot[i]) begin err_cnt++; $display("[TB] FAIL rr_ret%0d: got %b want %b", i, b_m_data_ok, exp_onehot[i]); end
      @(negedge clk);
    end
    b_s_data_ok = 1'b0;
    vec_cnt++; if (b_outst !== 3'd0) begin err_cnt++; $display("[TB] FAIL rr_drain: got %0d want 0", b_outst); end
  endtask

  task automatic test_spurious;
    @(negedge clk);
    a_s_data_ok = 1'b1;
    #1;
    vec_cnt++; if (a_m_data_ok !== 2'b00) begin err_cnt++; $display("[TB] FAIL sp_data_ok: got %b want 00", a_m_data_ok); end
    @(posedge clk); #1;
    vec_cnt++; if (a_err !== 1'b1) begin err_cnt++; $display("[TB] FAIL sp_err_set: got %b want 1", a_err); end
    @(negedge clk);
    a_s_data_ok = 1'b0;
    @(posedge clk); #1;
    vec_cnt++; if (a_err !== 1'b1) begin err_cnt++; $display("[TB] FAIL sp_err_hold: got %b want 1", a_err); end
    @(negedge clk);
    a_req = 2'b01; a_s_addr_ok = 1'b1;
    @(posedge clk); #1;
    vec_cnt++; if (a_outst !== 3'd1) begin err_cnt++; $display("[TB] FAIL sp_outst: got %0d want 1", a_outst); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    vec_cnt++; if (a_err !== 1'b0) begin err_cnt++; $display("[TB] FAIL sp_rst_err: got %b want 0", a_err); end
    vec_cnt++; if (a_outst !== 3'd0) begin err_cnt++; $display("[TB] FAIL sp_rst_outst: got %0d want 0", a_outst); end
    vec_cnt++; if (a_s_req !== 1'b0) begin err_cnt++; $display("[TB] FAIL sp_rst_s_req: got %b want 0", a_s_req); end
    vec_cnt++; if (a_m_addr_ok !== 2'b00) begin err_cnt++; $display("[TB] FAIL sp_rst_addr_ok: got %b want 00", a_m_addr_ok); end
    @(negedge clk);
    reset = 1'b0;
    a_req = 2'b00; a_s_addr_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_req = '0; a_wr = 2'b01; a_size_unused = '0;
    a_size = {2'b01, 2'b10};
    a_wstrb = {4'hC, 4'h3};
    a_addr = {A_ADDR1, A_ADDR0};
    a_wdata = {32'hD1D1_1111, 32'hD0D0_0000};
    a_s_addr_ok = 1'b0; a_s_data_ok = 1'b0; a_s_rdata = '0;
    b_req = '0; b_wr = '0; b_size = '0; b_wstrb = '1;
    b_addr = {32'hB000_0020, 32'hB000_0010, 32'hB000_0000};
    b_wdata = '0;
    b_s_addr_ok = 1'b0; b_s_data_ok = 1'b0; b_s_rdata = 32'hCAFE_0000;

    test_reset();
    test_fixed_priority();
    test_lock_hold();
    test_in_order_return();
    test_full_boundary();
    test_round_robin();
    test_spurious();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
